ping_echo_counter: RTL

//  Multi-channel ping/echo listener: a start strobe fires a one-cycle transmit request, then opens a

---
 rtl/ping_echo_counter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ping_echo_counter.sv
// Ping/echo listener: fires a transmit strobe, then counts per-channel
// echoes inside a fixed window, timestamping the first echo on each channel.
module ping_echo_counter #(
  parameter int N_CH     = 2,
  parameter int WIN_LEN  = 32768,
  parameter int BLANK    = 16,
  parameter int HOLD_CYC = 256,
  parameter int CNT_W    = 8,
  parameter int GAP_CYC  = 1024,
  parameter int WIN_W    = $clog2(WIN_LEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_stb,
  input  logic [N_CH-1:0]         echo_stb,
  input  logic                    auto_rearm,
  output logic                    tx_stb,
  output logic                    window_open,
  output logic [N_CH*CNT_W-1:0]   echo_cnt,
  output logic [N_CH*WIN_W-1:0]   first_ts,
  output logic [N_CH-1:0]         first_vld,
  output logic                    done_stb
);

  localparam int HOLD_W = $clog2(HOLD_CYC + 1);
  localparam int GAP_W  = $clog2(GAP_CYC + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PING   = 2'd1;
  localparam logic [1:0] S_LISTEN = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WIN_LEN - 1);
  localparam logic [WIN_W-1:0]  BLANK_V  = WIN_W'(BLANK);
  localparam logic [HOLD_W-1:0] HOLD_V   = HOLD_W'(HOLD_CYC);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [1:0]                   state_q, state_d;
  logic [WIN_W-1:0]             win_cnt_q, win_cnt_d;
  logic [GAP_W-1:0]             gap_q, gap_d;
  logic [N_CH-1:0][HOLD_W-1:0]  hold_q, hold_d;
  logic [N_CH*CNT_W-1:0]        echo_cnt_q, echo_cnt_d;
  logic [N_CH*WIN_W-1:0]        first_ts_q, first_ts_d;
  logic [N_CH-1:0]              first_vld_q, first_vld_d;
  logic                         tx_stb_q, tx_stb_d;
  logic                         window_open_q, window_open_d;
  logic                         done_stb_q, done_stb_d;
  logic                         listen_open;

  assign listen_open = (state_q == S_LISTEN) && (win_cnt_q >= BLANK_V);

  always_comb begin
    state_d     = state_q;
    win_cnt_d   = win_cnt_q;
    gap_d       = gap_q;
    hold_d      = hold_q;
    echo_cnt_d  = echo_cnt_q;
    first_ts_d  = first_ts_q;
    first_vld_d = first_vld_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_stb) state_d = S_PING;
      end
      S_PING: begin
        win_cnt_d = '0;
        state_d   = S_LISTEN;
      end
      S_LISTEN: begin
        win_cnt_d = win_cnt_q + 1'b1;
        if (win_cnt_q == WIN_LAST) begin
          state_d = S_DONE;
          gap_d   = '0;
        end
      end
      S_DONE: begin
        if (start_stb) begin
          state_d = S_PING;
        end else if (auto_rearm) begin
          if (gap_q == GAP_LAST) state_d = S_PING;
          else gap_d = gap_q + 1'b1;
        end else begin
          gap_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    for (int c = 0; c < N_CH; c++) begin
      if (hold_q[c] != '0) hold_d[c] = hold_q[c] - 1'b1;
      if (listen_open && echo_stb[c] && hold_q[c] == '0) begin
        hold_d[c] = HOLD_V;
        if (echo_cnt_q[c*CNT_W +: CNT_W] != CNT_MAX)
          echo_cnt_d[c*CNT_W +: CNT_W] =
            echo_cnt_q[c*CNT_W +: CNT_W] + 1'b1;
        if (!first_vld_q[c]) begin
          first_ts_d[c*WIN_W +: WIN_W] = win_cnt_q;
          first_vld_d[c] = 1'b1;
        end
      end
    end

    // Results of the previous window stay visible until the next ping.
    if (state_d == S_PING) begin
      hold_d      = '0;
      echo_cnt_d  = '0;
      first_ts_d  = '0;
      first_vld_d = '0;
      gap_d       = '0;
    end

    tx_stb_d      = (state_d == S_PING);
    window_open_d = (state_d == S_LISTEN);
    done_stb_d    = (state_q == S_LISTEN) && (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      win_cnt_q     <= '0;
      gap_q         <= '0;
      hold_q        <= '0;
      echo_cnt_q    <= '0;
      first_ts_q    <= '0;
      first_vld_q   <= '0;
      tx_stb_q      <= 1'b0;
      window_open_q <= 1'b0;
      done_stb_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_cnt_q     <= win_cnt_d;
      gap_q         <= gap_d;
      hold_q        <= hold_d;
      echo_cnt_q    <= echo_cnt_d;
      first_ts_q    <= first_ts_d;
      first_vld_q   <= first_vld_d;
      tx_stb_q      <= tx_stb_d;
      window_open_q <= window_open_d;
      done_stb_q    <= done_stb_d;
    end
  end

  assign tx_stb      = tx_stb_q;
  assign window_open = window_open_q;
  assign echo_cnt    = echo_cnt_q;
  assign first_ts    = first_ts_q;
  assign first_vld   = first_vld_q;
  assign done_stb    = done_stb_q;

endmodule
